if_id_reg: RTL and testbench

IF/ID pipeline register for the 16-bit five-stage pipeline. It captures the fetched instruction and PC+2 each cycle and presents them to decode. It also inserts bubbles on instruction-memory miss, holds on hazard stall, and squashes on taken branch/jump. A sticky halt latch stops further instructions entering decode once HALT is captured. It sits between fetch and decode, directly upstream of the decode logic that feeds the ID/EX register.

---
 rtl/if_id_reg_pkg.sv | 9 +
 rtl/dff.sv | 16 +
 rtl/reg16.sv | 33 +++
 rtl/if_id_reg.sv | 78 +++++++
 tb/tb_if_id_reg.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/if_id_reg_pkg.sv
// Shared pipeline constants for the IF/ID register, decode and ID/EX.
package if_id_reg_pkg;

  localparam int unsigned InstrWidth = 16;

  localparam logic [InstrWidth-1:0] NOP_INSTR  = 16'h0800;
  localparam logic [InstrWidth-1:0] HALT_INSTR = 16'h0000;

endpackage

// File: rtl/dff.sv
// Plain single-bit D flip-flop cell; no reset, no enable.
module dff (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg16.sv
// 16-bit register from dff cells with synchronous clear-to-value and load enable.
module reg16
  import if_id_reg_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic [InstrWidth-1:0] clr_val_i,
  input  logic                  en_i,
  input  logic [InstrWidth-1:0] d_i,
  output logic [InstrWidth-1:0] q_o
);

  logic [InstrWidth-1:0] q_d;

  // Clear dominates load; neither means hold.
  always_comb begin
    q_d = q_o;
    if (clr_i) begin
      q_d = clr_val_i;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  for (genvar i = 0; i < InstrWidth; i++) begin : g_bit
    dff u_dff (
      .clk_i (clk_i),
      .d_i   (q_d[i]),
      .q_o   (q_o[i])
    );
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures instruction and PC+2, inserts bubbles,
// holds on stall, squashes on flush and latches HALT until flushed or reset.
module if_id_reg
  import if_id_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [InstrWidth-1:0] instr_in,
  input  logic [InstrWidth-1:0] pc2_in,
  input  logic                  imem_rdy,
  input  logic                  stall,
  input  logic                  flush,
  output logic [InstrWidth-1:0] instr_out,
  output logic [InstrWidth-1:0] pc2_out,
  output logic                  valid_out,
  output logic                  halted_out,
  output logic                  pc_hold_out
);

  logic squash;
  logic bubble;
  logic load;
  logic instr_clr;
  logic valid_d;
  logic halted_d;

  always_comb begin
    squash    = rst | flush;
    bubble    = ~stall & (halted_out | ~imem_rdy);
    load      = ~squash & ~stall & ~halted_out & imem_rdy;
    instr_clr = squash | bubble;

    valid_d  = valid_out;
    halted_d = halted_out;
    if (squash) begin
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (!stall) begin
      valid_d = load;
      // Once halted, stays halted until a flush or reset clears it.
      halted_d = halted_out | (load & (instr_in == HALT_INSTR));
    end
  end

  reg16 u_instr_reg (
    .clk_i     (clk),
    .clr_i     (instr_clr),
    .clr_val_i (NOP_INSTR),
    .en_i      (load),
    .d_i       (instr_in),
    .q_o       (instr_out)
  );

  // Only reset clears PC+2; squash and bubbles leave it held.
  reg16 u_pc2_reg (
    .clk_i     (clk),
    .clr_i     (rst),
    .clr_val_i ('0),
    .en_i      (load),
    .d_i       (pc2_in),
    .q_o       (pc2_out)
  );

  dff u_valid_dff (
    .clk_i (clk),
    .d_i   (valid_d),
    .q_o   (valid_out)
  );

  dff u_halted_dff (
    .clk_i (clk),
    .d_i   (halted_d),
    .q_o   (halted_out)
  );

  assign pc_hold_out = stall | halted_out;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed vector table then random run vs model.
module tb_if_id_reg;

  localparam logic [15:0] Nop  = 16'h0800;
  localparam logic [15:0] Halt = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic [15:0] pc2_in;
  logic        imem_rdy;
  logic        stall;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc2_out;
  logic        valid_out;
  logic        halted_out;
  logic        pc_hold_out;

  int checks = 0;
  int errors = 0;

  // Reference state, advanced by the specification's priority rules.
  logic [15:0] m_instr;
  logic [15:0] m_pc2;
  logic        m_valid;
  logic        m_halted;

  always #5 clk = ~clk;

  if_id_reg dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .pc2_in      (pc2_in),
    .imem_rdy    (imem_rdy),
    .stall       (stall),
    .flush       (flush),
    .instr_out   (instr_out),
    .pc2_out     (pc2_out),
    .valid_out   (valid_out),
    .halted_out  (halted_out),
    .pc_hold_out (pc_hold_out)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        rdy;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic [15:0] e_instr;
    logic [15:0] e_pc2;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_instr = Nop; m_pc2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (flush) begin
      m_instr = Nop; m_valid = 1'b0; m_halted = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_halted) begin
      m_instr = Nop; m_valid = 1'b0;
    end else if (!imem_rdy) begin
      m_instr = Nop; m_valid = 1'b0;
    end else begin
      m_instr = instr_in; m_pc2 = pc2_in; m_valid = 1'b1;
      if (instr_in == Halt) m_halted = 1'b1;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic rd,
                       input logic [15:0] ins, input logic [15:0] pc);
    rst = r; stall = s; flush = f; imem_rdy = rd; instr_in = ins; pc2_in = pc;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic rd,
                              input logic [15:0] ins, input logic [15:0] pc,
                              input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic eh);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.rdy = rd; v.instr = ins; v.pc2 = pc;
    v.e_instr = ei; v.e_pc2 = ep; v.e_valid = ev; v.e_halted = eh;
    return v;
  endfunction

  initial begin
    //              rst stl fls rdy instr     pc2       e_instr   e_pc2    ev  eh
    vecs[0]  = mk(1, 0, 0, 1, 16'h4123, 16'h0002, Nop,      16'h0000, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 16'h4123, 16'h0002, Nop,      16'h0000, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 16'h4123, 16'h0002, 16'h4123, 16'h0002, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 16'hC0FF, 16'h0004, 16'hC0FF, 16'h0004, 1, 0);
    vecs[4]  = mk(0, 1, 0, 1, 16'h1111, 16'h0006, 16'hC0FF, 16'h0004, 1, 0);
    vecs[5]  = mk(0, 1, 0, 1, 16'h2222, 16'h0008, 16'hC0FF, 16'h0004, 1, 0);
    vecs[6]  = mk(0, 1, 0, 1, 16'h3333, 16'h000A, 16'hC0FF, 16'h0004, 1, 0);
    vecs[7]  = mk(0, 0, 0, 1, 16'h4444, 16'h000C, 16'h4444, 16'h000C, 1, 0);
    vecs[8]  = mk(0, 1, 1, 1, 16'h5555, 16'h000E, Nop,      16'h000C, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 16'h6666, 16'h0010, Nop,      16'h000C, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 16'h6666, 16'h0010, Nop,      16'h000C, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 16'h7777, 16'h0012, 16'h7777, 16'h0012, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, Halt,     16'h0014, Halt,     16'h0014, 1, 1);
    vecs[13] = mk(0, 0, 0, 1, 16'h4123, 16'h0016, Nop,      16'h0014, 0, 1);
    vecs[14] = mk(0, 1, 0, 1, 16'h4123, 16'h0018, Nop,      16'h0014, 0, 1);
    vecs[15] = mk(0, 0, 1, 1, 16'h4123, 16'h0018, Nop,      16'h0014, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 16'h4123, 16'h001A, 16'h4123, 16'h001A, 1, 0);
    vecs[17] = mk(0, 0, 0, 1, Halt,     16'h001C, Halt,     16'h001C, 1, 1);
    vecs[18] = mk(1, 1, 0, 1, 16'h4123, 16'h001E, Nop,      16'h0000, 0, 0);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_rdy = 1'b0;
    instr_in = '0; pc2_in = '0;
    m_instr = Nop; m_pc2 = '0; m_valid = 1'b0; m_halted = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].rdy,
            vecs[i].instr, vecs[i].pc2);
      check($sformatf("vec%0d instr", i), instr_out, vecs[i].e_instr);
      check($sformatf("vec%0d pc2", i), pc2_out, vecs[i].e_pc2);
      check($sformatf("vec%0d valid", i), {15'b0, valid_out}, {15'b0, vecs[i].e_valid});
      check($sformatf("vec%0d halted", i), {15'b0, halted_out}, {15'b0, vecs[i].e_halted});
      check($sformatf("vec%0d pc_hold", i), {15'b0, pc_hold_out},
            {15'b0, vecs[i].stall | vecs[i].e_halted});
    end

    // Halt then stall for several cycles then resume must stay halted.
    drive(0, 0, 0, 1, 16'h1234, 16'h0020);
    drive(0, 0, 0, 1, Halt, 16'h0022);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 1, 16'h5678, 16'h0024);
      check("halt_stall halted", {15'b0, halted_out}, 16'h0001);
      check("halt_stall instr", instr_out, Halt);
    end
    drive(0, 0, 0, 1, 16'h5678, 16'h0026);
    check("halt_resume instr", instr_out, Nop);
    check("halt_resume pc2", pc2_out, 16'h0022);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] ins;
      ins = ($urandom_range(0, 7) == 0) ? Halt : 16'($urandom);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            ins, 16'($urandom));
      check("rand instr", instr_out, m_instr);
      check("rand pc2", pc2_out, m_pc2);
      check("rand valid", {15'b0, valid_out}, {15'b0, m_valid});
      check("rand halted", {15'b0, halted_out}, {15'b0, m_halted});
      check("rand pc_hold", {15'b0, pc_hold_out}, {15'b0, stall | m_halted});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
